// File: rtl/bus_master_arbiter_pkg.sv
// bus_master_arbiter_pkg: shared FSM state type and channel-index width helper
package bus_master_arbiter_pkg;

    typedef enum logic [2:0] {CPU_OWNED, HOLD, AEN, GRANT, RELEASE} state_t;

    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_master_priority_select.sv
// bus_master_priority_select: picks the winning DMA channel from the request vector
//   request : per-channel request bits
//   last    : last granted channel (rotating mode searches from last+1)
//   found   : at least one request present
//   winner  : index of the selected channel
module bus_master_priority_select
    import bus_master_arbiter_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter bit ROTATE   = 0
) (
    input  logic [CHANNELS-1:0]                 request,
    input  logic [index_width(CHANNELS)-1:0]    last,
    output logic                                found,
    output logic [index_width(CHANNELS)-1:0]    winner
);

    localparam int W = index_width(CHANNELS);

    function automatic int chan(input int i, input int l);
        return ROTATE ? (l + 1 + i) % CHANNELS : i;
    endfunction

    // Scan from the lowest search position last so the earliest candidate wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (request[W'(chan(i, int'(last)))]) begin
                found  = 1'b1;
                winner = W'(chan(i, int'(last)));
            end
        end
    end

endmodule

// File: rtl/bus_master_arbiter.sv
// bus_master_arbiter: hands the system bus between the CPU and a set of DMA channels
//   clock, reset           : sole clock, asynchronous active-high reset
//   processor_status/lock_n: CPU status and LOCK, gate when arbitration may start
//   dma_request/terminal   : per-channel requests, end of transfer
//   dma_address/cpu_address: address sources for the system address mux
//   page_write/select/data : page register write port
//   hold_acknowledge, address_enable_n, dma_wait_n, dma_acknowledge_n, address : bus control outputs
module bus_master_arbiter
    import bus_master_arbiter_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int PAGE_WIDTH   = 4,
    parameter int OFFSET_WIDTH = 16,
    parameter bit ROTATE       = 0
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [2:0]                          processor_status,
    input  logic                                processor_lock_n,
    input  logic [CHANNELS-1:0]                 dma_request,
    input  logic                                dma_terminal_count,
    input  logic [OFFSET_WIDTH-1:0]             dma_address,
    input  logic [PAGE_WIDTH+OFFSET_WIDTH-1:0]  cpu_address,
    input  logic                                page_write,
    input  logic [index_width(CHANNELS)-1:0]    page_select,
    input  logic [PAGE_WIDTH-1:0]               page_data,
    output logic                                hold_acknowledge,
    output logic                                address_enable_n,
    output logic                                dma_wait_n,
    output logic [CHANNELS-1:0]                 dma_acknowledge_n,
    output logic [PAGE_WIDTH+OFFSET_WIDTH-1:0]  address
);

    localparam int W = index_width(CHANNELS);

    state_t                 state, state_next;
    logic [W-1:0]           latched, last_granted, winner;
    logic                   found, start;
    logic [PAGE_WIDTH-1:0]  page [CHANNELS];
    logic                   unused_status;

    assign unused_status = processor_status[2];

    bus_master_priority_select #(
        .CHANNELS (CHANNELS),
        .ROTATE   (ROTATE)
    ) u_select (
        .request (dma_request),
        .last    (last_granted),
        .found   (found),
        .winner  (winner)
    );

    // Arbitration only starts on a passive/idle CPU cycle that is not locked.
    assign start = found && processor_status[1:0] == 2'b11 && processor_lock_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= CPU_OWNED;
            latched      <= '0;
            last_granted <= W'(CHANNELS - 1);
            for (int i = 0; i < CHANNELS; i++)
                page[i] <= '0;
        end else begin
            state <= state_next;
            if (state == CPU_OWNED && start)
                latched <= winner;
            if (state == RELEASE)
                last_granted <= latched;
            if (page_write && int'(page_select) < CHANNELS)
                page[page_select] <= page_data;
        end
    end

    always_comb begin
        state_next        = state;
        dma_acknowledge_n = '1;
        case (state)
            CPU_OWNED: state_next = start ? HOLD : CPU_OWNED;
            HOLD:      state_next = dma_request[latched] ? AEN : CPU_OWNED;
            AEN:       state_next = GRANT;
            GRANT:     state_next = (dma_terminal_count || !dma_request[latched]) ? RELEASE : GRANT;
            default:   state_next = CPU_OWNED;
        endcase
        if (state == GRANT)
            dma_acknowledge_n[latched] = 1'b0;
        hold_acknowledge = state == AEN || state == GRANT;
        dma_wait_n       = !(state == AEN || state == GRANT);
        address_enable_n = state == AEN || state == GRANT || state == RELEASE;
        address          = state == GRANT ? {page[latched], dma_address} :
                           (state == CPU_OWNED || state == HOLD) ? cpu_address : '0;
    end

endmodule
